clk_en_scheduler: RTL and testbench

CLK_EN_SCHEDULER -- requirements
Module: clk_en_scheduler

---
 rtl/clk_en_scheduler_if.sv | 31 +++
 rtl/clk_en_scheduler.sv | 176 +++++++++++++++++
 tb/tb_clk_en_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_en_scheduler_if.sv
// Configuration write channel for clk_en_scheduler.
// Latency: pure wiring, no state.
// Backpressure: cfg_ready low blocks the writer until the scheduler is idle again.
interface clk_en_scheduler_if #(
    parameter int CHW  = 2,
    parameter int DIVW = 16
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_en;

    // Writer side: drives the request and its payload.
    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        output cfg_en,
        input  cfg_ready
    );

    // Scheduler side: consumes the request and answers with ready.
    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/clk_en_scheduler.sv
// Multi-channel clock-enable generator with shadowed ratio updates and global phase sync.
// Latency: a config write lands one cycle after its handshake; first tick D cycles after that.
// Backpressure: cfg_ready drops for one cycle after each accepted write (max one write per 2 cycles).
module clk_en_scheduler #(
    parameter int NCH  = 4,
    parameter int DIVW = 16
) (
    input  logic               dclk_in,
    input  logic               rst_n,
    clk_en_scheduler_if.slave  cfg,
    input  logic               sync,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     clk_out,
    output logic [NCH-1:0]     busy
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            handshake;
    logic            apply_st;
    logic [CHW-1:0]  ch_q;
    logic [DIVW-1:0] div_q;
    logic            en_q;

    assign handshake = cfg.cfg_valid && cfg.cfg_ready;
    assign apply_st  = (state == APPLY);

    // Config FSM state register.
    always_ff @(posedge dclk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Config FSM next state and ready: accept in IDLE, spend exactly one cycle in APPLY.
    always_comb begin
        state_n       = state;
        cfg.cfg_ready = 1'b0;
        case (state)
            IDLE: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    state_n = APPLY;
                end
            end
            APPLY: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Capture the write payload on the handshake so the channels see a stable request in APPLY.
    always_ff @(posedge dclk_in or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= '0;
            div_q <= DIVW'(1);
            en_q  <= 1'b0;
        end else if (handshake) begin
            ch_q  <= cfg.cfg_ch;
            div_q <= cfg.cfg_div;
            en_q  <= cfg.cfg_en;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIVW-1:0] act_r;
        logic [DIVW-1:0] shd_r;
        logic [DIVW-1:0] cnt_r;
        logic            en_r;
        logic            pend_r;
        logic            tick_r;
        logic            clk_r;

        logic [DIVW-1:0] act_n;
        logic [DIVW-1:0] shd_n;
        logic [DIVW-1:0] cnt_n;
        logic            en_n;
        logic            pend_n;
        logic            tick_n;

        logic [DIVW-1:0] eff;
        logic            wrap;
        logic            hit;

        // A stored ratio of 0 runs exactly like a ratio of 1.
        assign eff  = (act_r == '0) ? DIVW'(1) : act_r;
        assign wrap = en_r && (cnt_r >= (eff - DIVW'(1)));
        // Out-of-range channel indices never match, so such writes fall through untouched.
        assign hit  = apply_st && (ch_q == CHW'(i));

        // Channel next state: a config write beats sync, sync beats normal counting.
        always_comb begin
            act_n  = act_r;
            shd_n  = shd_r;
            cnt_n  = cnt_r;
            en_n   = en_r;
            pend_n = pend_r;
            tick_n = 1'b0;
            if (hit && (!en_r || !en_q)) begin
                // Idle channel or a disable: take effect at once, restart phase.
                act_n  = div_q;
                shd_n  = div_q;
                en_n   = en_q;
                cnt_n  = '0;
                pend_n = 1'b0;
            end else if (!hit && sync && en_r) begin
                // Realign to phase 0; a sync counts as a wrap for pending ratios.
                cnt_n = '0;
                if (pend_r) begin
                    act_n  = shd_r;
                    pend_n = 1'b0;
                end
            end else if (en_r) begin
                if (wrap) begin
                    cnt_n  = '0;
                    tick_n = 1'b1;
                    // A ratio written on this very edge waits for the following wrap.
                    if (pend_r && !hit) begin
                        act_n  = shd_r;
                        pend_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_r + DIVW'(1);
                end
                if (hit) begin
                    // Running channel: park the new ratio, last write wins.
                    shd_n  = div_q;
                    pend_n = 1'b1;
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge dclk_in or negedge rst_n) begin
            if (!rst_n) begin
                act_r  <= DIVW'(1);
                shd_r  <= DIVW'(1);
                cnt_r  <= '0;
                en_r   <= 1'b0;
                pend_r <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                act_r  <= act_n;
                shd_r  <= shd_n;
                cnt_r  <= cnt_n;
                en_r   <= en_n;
                pend_r <= pend_n;
                tick_r <= tick_n;
            end
        end

        // Square wave flips on every edge that sees a tick, so it freezes once ticks stop.
        always_ff @(posedge dclk_in or negedge rst_n) begin
            if (!rst_n) begin
                clk_r <= 1'b0;
            end else begin
                clk_r <= clk_r ^ tick_r;
            end
        end

        assign tick[i]    = tick_r;
        assign clk_out[i] = clk_r;
        assign busy[i]    = pend_r;
    end
endmodule

// File: tb/tb_clk_en_scheduler.sv
// Scoreboard bench for clk_en_scheduler (NCH=3 so an out-of-range index exists).
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares them.
// Every wait on the DUT is bounded.
module tb_clk_en_scheduler;
    localparam int NCH  = 3;
    localparam int DIVW = 16;
    localparam int CHW  = 2;

    logic           dclk_in;
    logic           rst_n;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] busy;
    int             cyc;
    int             checks;
    int             failures;

    clk_en_scheduler_if #(.CHW(CHW), .DIVW(DIVW)) cfg ();

    clk_en_scheduler #(.NCH(NCH), .DIVW(DIVW)) dut (
        .dclk_in (dclk_in),
        .rst_n   (rst_n),
        .cfg     (cfg),
        .sync    (sync),
        .tick    (tick),
        .clk_out (clk_out),
        .busy    (busy)
    );

    typedef struct {
        int         cyc;
        int         sel;
        logic [2:0] mask;
        logic [2:0] exp;
        string      name;
    } chk_t;

    chk_t q[$];

    initial begin
        dclk_in = 1'b0;
        forever #5 dclk_in = ~dclk_in;
    end

    initial begin
        cyc = 0;
    end

    always @(posedge dclk_in) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic void exp_at(input int c, input int sel, input logic [2:0] mask,
                                   input logic [2:0] exp, input string name);
        chk_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.mask = mask;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endfunction

    function automatic logic [2:0] sample(input int sel);
        case (sel)
            0:       return tick;
            1:       return clk_out;
            2:       return busy;
            default: return {2'b00, cfg.cfg_ready};
        endcase
    endfunction

    // Monitor: every cycle, compare all expectations that fall due now.
    always @(negedge dclk_in) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [2:0] act;
                act = sample(q[i].sel) & q[i].mask;
                checks++;
                if (act !== q[i].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%b required=%b", q[i].name, cyc, act, q[i].exp);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale cyc=%0d actual=unsampled required=%b", q[i].name, q[i].cyc, q[i].exp);
                q.delete(i);
            end
        end
    end

    task automatic tick_cycle();
        @(posedge dclk_in);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick_cycle();
    endtask

    // Issue one write; hs returns the cycle index of the handshake edge.
    task automatic cfg_write(input int ch, input int div, input bit en, output int hs);
        int guard;
        guard         = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = CHW'(ch);
        cfg.cfg_div   = DIVW'(div);
        cfg.cfg_en    = en;
        while (!cfg.cfg_ready && guard < 20) begin
            tick_cycle();
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL cfg_ready_timeout actual=0 required=1");
        end
        tick_cycle();
        cfg.cfg_valid = 1'b0;
        hs = cyc;
    endtask

    initial begin
        int h;
        int a;
        int a1;
        int a2;
        int k;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b1;
        sync          = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_div   = '0;
        cfg.cfg_en    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick_cycle();
        exp_at(cyc, 0, 3'b111, 3'b000, "rst_tick");
        exp_at(cyc, 1, 3'b111, 3'b000, "rst_clk_out");
        exp_at(cyc, 2, 3'b111, 3'b000, "rst_busy");
        exp_at(cyc, 3, 3'b001, 3'b001, "rst_ready");
        tick_cycle();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) exp_at(cyc + i, 0, 3'b111, 3'b000, "idle_no_tick");

        // Out-of-range channel: handshake happens, nothing changes.
        cfg_write(3, 2, 1'b1, h);
        a = h + 1;
        exp_at(h, 3, 3'b001, 3'b000, "oor_accepted");
        for (int i = 0; i <= 4; i++) exp_at(a + i, 0, 3'b111, 3'b000, "oor_no_tick");
        exp_at(a + 2, 2, 3'b111, 3'b000, "oor_no_busy");
        wait_until(a + 5);

        // D=0 on ch1 behaves as D=1: tick held high, clk_out toggles every cycle.
        cfg_write(1, 0, 1'b1, h);
        a1 = h + 1;
        exp_at(a1, 0, 3'b010, 3'b000, "d0_apply_cycle");
        for (int i = 1; i <= 4; i++) begin
            exp_at(a1 + i, 0, 3'b010, 3'b010, "d0_tick_high");
            exp_at(a1 + i, 1, 3'b010, (i % 2 == 0) ? 3'b010 : 3'b000, "d0_clk_toggle");
        end
        wait_until(a1 + 5);
        // Disable ch1 (lands at a1+7): the last tick flips clk_out to 0, then it holds.
        cfg_write(1, 0, 1'b0, h);
        a = h + 1;
        for (int i = 0; i <= 3; i++) begin
            exp_at(a + i, 0, 3'b010, 3'b000, "dis1_no_tick");
            exp_at(a + i, 1, 3'b010, 3'b000, "dis1_clk_hold");
        end
        wait_until(a + 4);

        // ch0 D=2: ticks at A+2, A+4, ...; clk_out period 4.
        cfg_write(0, 2, 1'b1, h);
        a = h + 1;
        for (int i = 1; i <= 6; i++) exp_at(a + i, 0, 3'b001, (i % 2 == 0) ? 3'b001 : 3'b000, "d2_tick");
        exp_at(a + 2, 1, 3'b001, 3'b000, "d2_clk");
        exp_at(a + 3, 1, 3'b001, 3'b001, "d2_clk");
        exp_at(a + 4, 1, 3'b001, 3'b001, "d2_clk");
        exp_at(a + 5, 1, 3'b001, 3'b000, "d2_clk");
        exp_at(a + 6, 1, 3'b001, 3'b000, "d2_clk");
        exp_at(a + 7, 1, 3'b001, 3'b001, "d2_clk");
        wait_until(a + 8);
        cfg_write(0, 2, 1'b0, h);
        a = h + 1;
        for (int i = 0; i <= 3; i++) exp_at(a + i, 0, 3'b001, 3'b000, "dis0_no_tick");
        wait_until(a + 4);

        // ch1 D=5, then D=3 written at phase 2: one more period of 5, then 3.
        cfg_write(1, 5, 1'b1, h);
        a = h + 1;
        exp_at(a + 4, 0, 3'b010, 3'b000, "d5_before_first");
        exp_at(a + 5, 0, 3'b010, 3'b010, "d5_first_tick");
        wait_until(a + 5);
        cfg_write(1, 3, 1'b1, h);
        a2 = h + 1;
        exp_at(h, 2, 3'b010, 3'b000, "busy1_before");
        exp_at(a2, 2, 3'b010, 3'b010, "busy1_set");
        exp_at(a2 + 2, 2, 3'b010, 3'b010, "busy1_held");
        exp_at(a2 + 3, 2, 3'b010, 3'b000, "busy1_clear");
        exp_at(a2 + 1, 0, 3'b010, 3'b000, "d5_tail");
        exp_at(a2 + 2, 0, 3'b010, 3'b000, "d5_tail");
        exp_at(a2 + 3, 0, 3'b010, 3'b010, "d5_end_tick");
        exp_at(a2 + 4, 0, 3'b010, 3'b000, "d3_gap");
        exp_at(a2 + 5, 0, 3'b010, 3'b000, "d3_gap");
        exp_at(a2 + 6, 0, 3'b010, 3'b010, "d3_tick");
        exp_at(a2 + 9, 0, 3'b010, 3'b010, "d3_tick");
        wait_until(a2 + 10);

        // Back-to-back writes with valid held, then sync, then sync loading a pending ratio.
        k = cyc;
        exp_at(k,     3, 3'b001, 3'b001, "b2b_ready");
        exp_at(k + 1, 3, 3'b001, 3'b000, "b2b_ready");
        exp_at(k + 2, 3, 3'b001, 3'b001, "b2b_ready");
        exp_at(k + 3, 3, 3'b001, 3'b000, "b2b_ready");
        exp_at(k + 5,  0, 3'b001, 3'b000, "b2b_ch0_gap");
        exp_at(k + 6,  0, 3'b001, 3'b001, "b2b_ch0_tick");
        exp_at(k + 10, 0, 3'b001, 3'b001, "b2b_ch0_tick");
        exp_at(k + 6,  0, 3'b100, 3'b000, "b2b_ch2_gap");
        exp_at(k + 9,  0, 3'b100, 3'b000, "b2b_ch2_gap");
        exp_at(k + 10, 0, 3'b100, 3'b100, "b2b_ch2_tick");
        exp_at(k + 14, 0, 3'b101, 3'b000, "sync_suppress");
        exp_at(k + 16, 0, 3'b101, 3'b000, "sync_realigned");
        exp_at(k + 17, 0, 3'b001, 3'b000, "sync_ch0_gap");
        exp_at(k + 18, 0, 3'b001, 3'b001, "sync_ch0_tick");
        exp_at(k + 19, 0, 3'b100, 3'b000, "sync_ch2_gap");
        exp_at(k + 20, 0, 3'b100, 3'b100, "sync_ch2_tick");
        exp_at(k + 22, 0, 3'b001, 3'b001, "pend_ch0_tick");
        exp_at(k + 23, 2, 3'b001, 3'b001, "pend_busy");
        exp_at(k + 24, 2, 3'b001, 3'b001, "pend_busy");
        exp_at(k + 25, 2, 3'b001, 3'b000, "sync_load_busy");
        exp_at(k + 25, 0, 3'b101, 3'b000, "sync2_suppress");
        exp_at(k + 26, 0, 3'b101, 3'b000, "sync2_realigned");
        exp_at(k + 27, 0, 3'b001, 3'b001, "sync_load_d2");
        exp_at(k + 28, 0, 3'b001, 3'b000, "sync_load_d2");
        exp_at(k + 29, 0, 3'b001, 3'b001, "sync_load_d2");
        exp_at(k + 30, 0, 3'b100, 3'b000, "sync2_ch2_gap");
        exp_at(k + 31, 0, 3'b100, 3'b100, "sync2_ch2_tick");
        cfg_write(0, 4, 1'b1, h);
        cfg_write(2, 6, 1'b1, h);
        wait_until(k + 13);
        sync = 1'b1;
        tick_cycle();
        sync = 1'b0;
        wait_until(k + 21);
        cfg_write(0, 2, 1'b1, h);
        wait_until(k + 24);
        sync = 1'b1;
        tick_cycle();
        sync = 1'b0;
        wait_until(k + 32);

        // Reset while a ratio is pending and a second write is in APPLY.
        cfg_write(2, 9, 1'b1, h);
        a = h + 1;
        exp_at(a, 2, 3'b100, 3'b100, "pre_rst_busy");
        wait_until(a + 1);
        exp_at(a + 1, 2, 3'b100, 3'b100, "pre_rst_busy");
        cfg_write(2, 7, 1'b1, h);
        exp_at(h, 0, 3'b111, 3'b000, "async_rst_tick");
        exp_at(h, 1, 3'b111, 3'b000, "async_rst_clk_out");
        exp_at(h, 2, 3'b111, 3'b000, "async_rst_busy");
        exp_at(h, 3, 3'b001, 3'b001, "async_rst_ready");
        #1 rst_n = 1'b0;
        tick_cycle();
        tick_cycle();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) exp_at(h + 2 + i, 0, 3'b111, 3'b000, "post_rst_no_tick");
        exp_at(h + 3, 3, 3'b001, 3'b001, "post_rst_ready");
        exp_at(h + 4, 2, 3'b111, 3'b000, "post_rst_busy");
        exp_at(h + 5, 1, 3'b111, 3'b000, "post_rst_clk_out");
        wait_until(h + 10);

        repeat (2) tick_cycle();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
